// File: rtl/matrix_pkg.sv
// Shared types and helpers for the sequential matrix multiplier: FSM states,
// counter width sizing and packed row-major element addressing.
package matrix_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Width of a counter that indexes 0..n-1; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // LSB of element (r,c) in a rows x cols matrix of w-bit words; (0,0) sits in the MSBs.
    function automatic int elem_lsb(input int rows, input int cols, input int r, input int c, input int w);
        return (rows * cols - (cols * r + c) - 1) * w;
    endfunction

endpackage

// File: rtl/matrix_mac_unit.sv
// Single multiply-accumulate step: sum = a*b + (clr_acc ? 0 : acc), wrapped to WORD_SIZE bits.
module matrix_mac_unit #(
    parameter int WORD_SIZE = 32
) (
    input  logic [WORD_SIZE-1:0] a,
    input  logic [WORD_SIZE-1:0] b,
    input  logic [WORD_SIZE-1:0] acc,
    input  logic                 clr_acc,
    output logic [WORD_SIZE-1:0] sum
);

    logic [WORD_SIZE-1:0] prod;
    logic [WORD_SIZE-1:0] base;

    assign prod = a * b;
    assign base = clr_acc ? '0 : acc;
    assign sum  = prod + base;

endmodule

// File: rtl/matrix_mul_seq.sv
// Time-multiplexed matrix multiply MP = A x B: one MAC per cycle walks r, c, k,
// with valid/ready handshakes on the operand and result sides.
module matrix_mul_seq
    import matrix_pkg::*;
#(
    parameter int WORD_SIZE = 32,
    parameter int A_ROWS    = 2,
    parameter int A_COLS    = 2,
    parameter int B_COLS    = 1
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                clear,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [A_ROWS*A_COLS*WORD_SIZE-1:0]  A,
    input  logic [A_COLS*B_COLS*WORD_SIZE-1:0]  B,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [A_ROWS*B_COLS*WORD_SIZE-1:0]  MP,
    output logic                                busy
);

    localparam int W  = WORD_SIZE;
    localparam int RW = idx_width(A_ROWS);
    localparam int CW = idx_width(B_COLS);
    localparam int KW = idx_width(A_COLS);

    localparam logic [RW-1:0] R_LAST = RW'(A_ROWS - 1);
    localparam logic [CW-1:0] C_LAST = CW'(B_COLS - 1);
    localparam logic [KW-1:0] K_LAST = KW'(A_COLS - 1);

    state_t                          state_reg;
    logic [A_ROWS*A_COLS*W-1:0]      a_reg;
    logic [A_COLS*B_COLS*W-1:0]      b_reg;
    logic [W-1:0]                    acc_reg;
    logic [RW-1:0]                   r_reg;
    logic [CW-1:0]                   c_reg;
    logic [KW-1:0]                   k_reg;

    logic [W-1:0]                    a_sel;
    logic [W-1:0]                    b_sel;
    logic [W-1:0]                    mac_sum;
    logic                            mp_write;

    // Operand selection: A[r][k] and B[k][c] from the registered flat vectors.
    always_comb begin
        a_sel = '0;
        for (int i = 0; i < A_ROWS; i++)
            for (int j = 0; j < A_COLS; j++)
                if (r_reg == RW'(i) && k_reg == KW'(j))
                    a_sel = a_reg[elem_lsb(A_ROWS, A_COLS, i, j, W) +: W];
    end

    always_comb begin
        b_sel = '0;
        for (int i = 0; i < A_COLS; i++)
            for (int j = 0; j < B_COLS; j++)
                if (k_reg == KW'(i) && c_reg == CW'(j))
                    b_sel = b_reg[elem_lsb(A_COLS, B_COLS, i, j, W) +: W];
    end

    matrix_mac_unit #(
        .WORD_SIZE(W)
    ) u_mac (
        .a       (a_sel),
        .b       (b_sel),
        .acc     (acc_reg),
        .clr_acc (k_reg == '0),
        .sum     (mac_sum)
    );

    assign mp_write = (state_reg == RUN) && (k_reg == K_LAST) && !clear;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            a_reg     <= '0;
            b_reg     <= '0;
            acc_reg   <= '0;
            r_reg     <= '0;
            c_reg     <= '0;
            k_reg     <= '0;
        end else if (clear) begin
            state_reg <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            acc_reg   <= '0;
            r_reg     <= '0;
            c_reg     <= '0;
            k_reg     <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        a_reg     <= A;
                        b_reg     <= B;
                        acc_reg   <= '0;
                        r_reg     <= '0;
                        c_reg     <= '0;
                        k_reg     <= '0;
                        state_reg <= RUN;
                        in_ready  <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                RUN: begin
                    if (k_reg == K_LAST) begin
                        // Element finished: MP(r,c) is written by the element registers below.
                        acc_reg <= '0;
                        k_reg   <= '0;
                        if (c_reg == C_LAST) begin
                            c_reg <= '0;
                            if (r_reg == R_LAST) begin
                                r_reg     <= '0;
                                state_reg <= DONE;
                                out_valid <= 1'b1;
                            end else begin
                                r_reg <= r_reg + 1'b1;
                            end
                        end else begin
                            c_reg <= c_reg + 1'b1;
                        end
                    end else begin
                        acc_reg <= mac_sum;
                        k_reg   <= k_reg + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_reg <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

    // One result register per MP element; clear leaves them untouched.
    for (genvar gi = 0; gi < A_ROWS; gi++) begin : g_row
        for (genvar gj = 0; gj < B_COLS; gj++) begin : g_col
            localparam logic [RW-1:0] RI = RW'(gi);
            localparam logic [CW-1:0] CI = CW'(gj);
            logic [W-1:0] elem_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    elem_reg <= '0;
                else if (mp_write && r_reg == RI && c_reg == CI)
                    elem_reg <= mac_sum;
            end

            assign MP[elem_lsb(A_ROWS, B_COLS, gi, gj, W) +: W] = elem_reg;
        end
    end

endmodule
